test_istream_q: RTL and testbench

TEST_ISTREAM_Q -- requirements
Module: test_istream_q

---
 rtl/test_istream_q.sv | 165 ++++++++++++++++
 tb/tb_test_istream_q.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_istream_q.sv
`default_nettype none
// ============================================================================
// Module : test_istream_q
// Desc   : Queued stream source; emits messages with a fixed or LFSR-random gap.
// Rev    : 1.0  initial release
// ============================================================================
module test_istream_q #(
    parameter type         t_msg        = logic [31:0],
    parameter int          p_depth      = 8,
    parameter int          p_intv_delay = 0,
    parameter int          p_rand_mode  = 0,
    parameter logic [15:0] p_seed       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  t_msg        push_msg,
    input  logic        push_val,
    output logic        push_rdy,
    output t_msg        msg,
    output logic        val,
    input  logic        rdy,
    output logic [31:0] sent_count,
    output logic        done
);

    localparam int              c_aw      = $clog2(p_depth);
    localparam logic [c_aw:0]   c_full    = p_depth[c_aw:0];
    localparam logic [c_aw:0]   c_cnt_one = {{c_aw{1'b0}}, 1'b1};
    localparam logic [7:0]      c_fixed_d = p_intv_delay[7:0];
    localparam int              c_mod_i   = p_intv_delay + 1;
    localparam logic [15:0]     c_mod     = c_mod_i[15:0];
    localparam logic [15:0]     c_mask    = 16'hB400;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_delay = 2'd1;
    localparam logic [1:0] c_st_send  = 2'd2;

    generate
        if (p_seed == 16'h0000) begin : g_seed_check
            $error("test_istream_q: p_seed must be nonzero");
        end
        if ((p_depth < 2) || ((p_depth & (p_depth - 1)) != 0)) begin : g_depth_check
            $error("test_istream_q: p_depth must be a power of two >= 2");
        end
    endgenerate

    t_msg              r_mem [p_depth];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic [15:0]       r_lfsr;
    logic [15:0]       w_lfsr_adv;
    logic [7:0]        w_rand_d;
    logic [7:0]        w_d;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_load;
    logic              w_remain;

    assign w_full   = (r_count == c_full);
    assign w_empty  = (r_count == '0);
    assign push_rdy = ~w_full;
    assign w_push   = push_val & ~w_full;
    assign val      = (r_state == c_st_send);
    assign w_pop    = val & rdy;
    assign msg      = val ? r_mem[r_rd_ptr] : '0;
    assign done     = (r_state == c_st_idle) & w_empty;

    // Something is left to send after a pop if two or more entries were held
    // or a new entry lands on the same edge.
    assign w_remain = (r_count[c_aw:1] != '0) | w_push;

    // The gap uses the current LFSR value; the LFSR steps once per load.
    assign w_rand_d   = 8'(r_lfsr % c_mod);
    assign w_d        = (p_rand_mode != 0) ? w_rand_d : c_fixed_d;
    assign w_lfsr_adv = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_mask : 16'h0000);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_load = 1'b1;
                    if (w_d == 8'd0) begin
                        w_state_nxt = c_st_send;
                    end else begin
                        w_state_nxt = c_st_delay;
                        w_cnt_nxt   = w_d;
                    end
                end
            end
            c_st_delay: begin
                w_cnt_nxt = r_cnt - 8'd1;
                if (r_cnt <= 8'd1) begin
                    w_state_nxt = c_st_send;
                end
            end
            c_st_send: begin
                if (w_pop) begin
                    if (w_remain) begin
                        w_load = 1'b1;
                        if (w_d == 8'd0) begin
                            w_state_nxt = c_st_send;
                        end else begin
                            w_state_nxt = c_st_delay;
                            w_cnt_nxt   = w_d;
                        end
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= 8'd0;
            r_lfsr     <= p_seed;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            sent_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_lfsr <= w_lfsr_adv;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_aw'(1);
                sent_count <= sent_count + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= push_msg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_test_istream_q.sv
`default_nettype none
// ============================================================================
// Module : tb_test_istream_q
// Desc   : Directed self-checking bench for test_istream_q (three configurations).
// Rev    : 1.0  initial release
// ============================================================================
module tb_test_istream_q;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // a: fixed gap 0, depth 4 / b: fixed gap 2 / c: random gap 0..3
    logic [31:0] a_push_msg = '0, a_msg, a_sent;
    logic        a_push_val = 1'b0, a_push_rdy, a_val, a_rdy = 1'b1, a_done;
    logic [31:0] b_push_msg = '0, b_msg, b_sent;
    logic        b_push_val = 1'b0, b_push_rdy, b_val, b_rdy = 1'b1, b_done;
    logic [31:0] c_push_msg = '0, c_msg, c_sent;
    logic        c_push_val = 1'b0, c_push_rdy, c_val, c_rdy = 1'b1, c_done;

    int errors = 0;
    int checks = 0;
    int gap_run [2][19];

    test_istream_q #(.t_msg(logic [31:0]), .p_depth(4), .p_intv_delay(0),
                     .p_rand_mode(0), .p_seed(16'hACE1)) u_a (
        .clk(clk), .rst(rst), .push_msg(a_push_msg), .push_val(a_push_val),
        .push_rdy(a_push_rdy), .msg(a_msg), .val(a_val), .rdy(a_rdy),
        .sent_count(a_sent), .done(a_done));

    test_istream_q #(.t_msg(logic [31:0]), .p_depth(8), .p_intv_delay(2),
                     .p_rand_mode(0), .p_seed(16'hACE1)) u_b (
        .clk(clk), .rst(rst), .push_msg(b_push_msg), .push_val(b_push_val),
        .push_rdy(b_push_rdy), .msg(b_msg), .val(b_val), .rdy(b_rdy),
        .sent_count(b_sent), .done(b_done));

    test_istream_q #(.t_msg(logic [31:0]), .p_depth(8), .p_intv_delay(3),
                     .p_rand_mode(1), .p_seed(16'hACE1)) u_c (
        .clk(clk), .rst(rst), .push_msg(c_push_msg), .push_val(c_push_val),
        .push_rdy(c_push_rdy), .msg(c_msg), .val(c_val), .rdy(c_rdy),
        .sent_count(c_sent), .done(c_done));

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        a_push_val = 1'b0;
        b_push_val = 1'b0;
        c_push_val = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        a_push_val = 1'b1;
        a_push_msg = 32'hDEAD;
        tick();
        tick();
        rst        = 1'b0;
        a_push_val = 1'b0;
        checks++; if (a_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b want 0", a_val); end
        checks++; if (a_msg !== 32'h0) begin errors++; $display("FAIL reset_msg: got %h want 0", a_msg); end
        checks++; if (a_push_rdy !== 1'b1) begin errors++; $display("FAIL reset_push_rdy: got %b want 1", a_push_rdy); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL reset_done: got %b want 1", a_done); end
        checks++; if (a_sent !== 32'd0) begin errors++; $display("FAIL reset_sent: got %0d want 0", a_sent); end
        checks++; if (b_done !== 1'b1 || c_done !== 1'b1) begin errors++; $display("FAIL reset_done_bc: got %b%b want 11", b_done, c_done); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pushes  [3] = '{32'h11, 32'h22, 32'h33};
        logic        exp_val [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_msg [6] = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
        do_reset();
        a_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                a_push_val = 1'b1;
                a_push_msg = pushes[i];
            end else begin
                a_push_val = 1'b0;
            end
            tick();
            checks++;
            if (a_val !== exp_val[i] || a_msg !== exp_msg[i]) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got val=%b msg=%h want val=%b msg=%h", i, a_val, a_msg, exp_val[i], exp_msg[i]);
            end
        end
        checks++; if (a_sent !== 32'd3) begin errors++; $display("FAIL b2b_sent: got %0d want 3", a_sent); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", a_done); end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_rdy      = 1'b0;
        a_push_val = 1'b1;
        a_push_msg = 32'h5;
        tick();
        a_push_val = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (a_val !== 1'b1 || a_msg !== 32'h5) begin
                errors++;
                $display("FAIL bp_hold%0d: got val=%b msg=%h want val=1 msg=5", k, a_val, a_msg);
            end
            tick();
        end
        a_rdy = 1'b1;
        tick();
        checks++; if (a_val !== 1'b0) begin errors++; $display("FAIL bp_after_val: got %b want 0", a_val); end
        checks++; if (a_sent !== 32'd1) begin errors++; $display("FAIL bp_sent: got %0d want 1", a_sent); end
    endtask

    task automatic test_full();
        int n;
        do_reset();
        a_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_push_val = 1'b1;
            a_push_msg = 32'h41 + 32'(i);
            tick();
            if (i == 2) begin
                checks++; if (a_push_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy3: got %b want 1", a_push_rdy); end
            end
            if (i >= 3) begin
                checks++; if (a_push_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy%0d: got %b want 0", i + 1, a_push_rdy); end
            end
        end
        a_push_val = 1'b0;
        a_rdy      = 1'b1;
        n          = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (a_val === 1'b1) begin
                if (n < 4) begin
                    checks++;
                    if (a_msg !== 32'h41 + 32'(n)) begin
                        errors++;
                        $display("FAIL full_order%0d: got %h want %h", n, a_msg, 32'h41 + 32'(n));
                    end
                end
                n++;
            end
            tick();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL full_count: got %0d want 4", n); end
        checks++; if (a_done !== 1'b1 || a_push_rdy !== 1'b1) begin errors++; $display("FAIL full_drained: got done=%b push_rdy=%b want 1 1", a_done, a_push_rdy); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        a_rdy      = 1'b1;
        a_push_val = 1'b1;
        a_push_msg = 32'h61;
        tick();
        a_push_val = 1'b0;
        tick();
        tick();
        a_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_push_val = 1'b1;
            a_push_msg = 32'h71 + 32'(i);
            tick();
        end
        a_push_val = 1'b0;
        tick();
        checks++; if (a_val !== 1'b1 || a_sent !== 32'd1) begin errors++; $display("FAIL mid_pre: got val=%b sent=%0d want 1 1", a_val, a_sent); end
        rst        = 1'b1;
        a_push_val = 1'b1;
        a_push_msg = 32'h99;
        a_rdy      = 1'b1;
        tick();
        rst        = 1'b0;
        a_push_val = 1'b0;
        checks++; if (a_val !== 1'b0) begin errors++; $display("FAIL mid_val: got %b want 0", a_val); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL mid_done: got %b want 1", a_done); end
        checks++; if (a_sent !== 32'd0) begin errors++; $display("FAIL mid_sent: got %0d want 0", a_sent); end
        a_push_val = 1'b1;
        a_push_msg = 32'h77;
        tick();
        a_push_val = 1'b0;
        tick();
        checks++; if (a_val !== 1'b1 || a_msg !== 32'h77) begin errors++; $display("FAIL mid_new: got val=%b msg=%h want 1 77", a_val, a_msg); end
        tick();
        checks++; if (a_sent !== 32'd1 || a_done !== 1'b1) begin errors++; $display("FAIL mid_new_sent: got sent=%0d done=%b want 1 1", a_sent, a_done); end
    endtask

    task automatic test_gap();
        logic        exp_val [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_msg [8] = '{32'h0, 32'h0, 32'h0, 32'hA, 32'h0, 32'h0, 32'hB, 32'h0};
        do_reset();
        b_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_push_val = (i < 2);
            b_push_msg = (i == 0) ? 32'hA : 32'hB;
            tick();
            checks++;
            if (b_val !== exp_val[i] || b_msg !== exp_msg[i]) begin
                errors++;
                $display("FAIL gap_cycle%0d: got val=%b msg=%h want val=%b msg=%h", i, b_val, b_msg, exp_val[i], exp_msg[i]);
            end
        end
        checks++; if (b_sent !== 32'd2 || b_done !== 1'b1 || b_push_rdy !== 1'b1) begin
            errors++; $display("FAIL gap_end: got sent=%0d done=%b push_rdy=%b want 2 1 1", b_sent, b_done, b_push_rdy);
        end
        // Reset while waiting out a gap must discard the queued message.
        b_push_val = 1'b1;
        b_push_msg = 32'hC;
        tick();
        b_push_val = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (b_val !== 1'b0 || b_done !== 1'b1 || b_sent !== 32'd0) begin
            errors++; $display("FAIL gap_rst: got val=%b done=%b sent=%0d want 0 1 0", b_val, b_done, b_sent);
        end
    endtask

    task automatic test_random(input int run);
        logic [15:0] l;
        int          exp_gap [19];
        int          fires, zeros, pushed, cyc;
        l = 16'hACE1;
        l = lfsr_next(l);
        for (int k = 0; k < 19; k++) begin
            exp_gap[k] = int'(l % 16'd4);
            l          = lfsr_next(l);
        end
        do_reset();
        c_rdy  = 1'b0;
        pushed = 0;
        for (int i = 0; i < 8; i++) begin
            c_push_val = 1'b1;
            c_push_msg = 32'hC0 + 32'(pushed);
            pushed++;
            tick();
        end
        c_rdy = 1'b1;
        fires = 0;
        zeros = 0;
        cyc   = 0;
        while (fires < 20 && cyc < 300) begin
            if (c_push_rdy === 1'b1 && pushed < 20) begin
                c_push_val = 1'b1;
                c_push_msg = 32'hC0 + 32'(pushed);
                pushed++;
            end else begin
                c_push_val = 1'b0;
            end
            if (c_val === 1'b1) begin
                checks++;
                if (c_msg !== 32'hC0 + 32'(fires)) begin
                    errors++;
                    $display("FAIL rnd%0d_msg%0d: got %h want %h", run, fires, c_msg, 32'hC0 + 32'(fires));
                end
                if (fires > 0) gap_run[run][fires-1] = zeros;
                zeros = 0;
                fires++;
            end else if (fires > 0) begin
                zeros++;
            end
            tick();
            cyc++;
        end
        c_push_val = 1'b0;
        tick();
        checks++; if (fires != 20) begin errors++; $display("FAIL rnd%0d_fires: got %0d want 20 (cycle budget)", run, fires); end
        checks++; if (c_sent !== 32'd20 || c_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_end: got sent=%0d done=%b want 20 1", run, c_sent, c_done); end
        if (fires == 20) begin
            for (int k = 0; k < 19; k++) begin
                checks++;
                if (gap_run[run][k] != exp_gap[k] || gap_run[run][k] > 3) begin
                    errors++;
                    $display("FAIL rnd%0d_gap%0d: got %0d want %0d", run, k, gap_run[run][k], exp_gap[k]);
                end
                if (run == 1) begin
                    checks++;
                    if (gap_run[1][k] != gap_run[0][k]) begin
                        errors++;
                        $display("FAIL rnd_repeat_gap%0d: got %0d want %0d", k, gap_run[1][k], gap_run[0][k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_full();
        test_reset_midstream();
        test_gap();
        test_random(0);
        test_random(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
